// File: rtl/cms_pkg.sv
// Shared constants for the continuous monitoring system: opcode values,
// packet field layout and the decoder's classification record.
package cms_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam int OPCODE_W   = 7;
   localparam int INSTR_W    = 32;
   localparam int PC_OFFSET  = 0;

   // Instruction word sits directly above the program counter in the packet.
   function automatic int instr_offset(input int xlen);
      return xlen;
   endfunction

endpackage

// File: rtl/cms_instr_decoder.sv
// Combinational opcode classifier. With CMS_BRANCH_FILTER_EN defined only
// control-flow instructions are events; otherwise every valid commit is.
module cms_instr_decoder
   import cms_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                pc_valid,
   output logic                is_branch,
   output logic                is_jal,
   output logic                is_jalr,
   output logic                is_event
);

   always_comb begin
      is_branch = (opcode == OPC_BRANCH);
      is_jal    = (opcode == OPC_JAL);
      is_jalr   = (opcode == OPC_JALR);
`ifdef CMS_BRANCH_FILTER_EN
      is_event  = pc_valid & (is_branch | is_jal | is_jalr);
`else
      is_event  = pc_valid;
`endif
   end

endmodule

// File: rtl/continuous_monitoring_system.sv
// Captures committed instructions as {instr, pc} beats on an AXI-Stream master
// with tlast grouping. Optional control-flow filter: CMS_BRANCH_FILTER_EN.
module continuous_monitoring_system
   import cms_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int AXI_DATA_WIDTH = XLEN + 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [INSTR_W-1:0]        instr,
   input  logic [XLEN-1:0]           pc,
   input  logic                      pc_valid,
   output logic                      M_AXIS_tvalid,
   input  logic                      M_AXIS_tready,
   output logic [AXI_DATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                      M_AXIS_tlast,
   input  logic [31:0]               tlast_interval
);

   localparam int INSTR_OFF = instr_offset(XLEN);

   logic                      is_branch;
   logic                      is_jal;
   logic                      is_jalr;
   logic                      is_event;
   logic                      unused_class;

   logic                      tvalid_q, tvalid_d;
   logic                      tlast_q, tlast_d;
   logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [31:0]               beat_cnt_q, beat_cnt_d;

   logic                      xfer;
   logic                      load;
   logic [31:0]               cnt_after;
   logic                      last_for_load;
   logic [AXI_DATA_WIDTH-1:0] packet;

   cms_instr_decoder u_decoder (
      .opcode    (instr[OPCODE_W-1:0]),
      .pc_valid  (pc_valid),
      .is_branch (is_branch),
      .is_jal    (is_jal),
      .is_jalr   (is_jalr),
      .is_event  (is_event)
   );

   assign unused_class = is_branch ^ is_jal ^ is_jalr;

   always_comb begin
      packet = '0;
      packet[PC_OFFSET +: XLEN]       = pc;
      packet[INSTR_OFF +: INSTR_W]    = instr;

      xfer = tvalid_q & M_AXIS_tready;
      // A stalled beat blocks the register, so events during a stall are lost.
      load = is_event & (~tvalid_q | M_AXIS_tready);

      // Counter value as it will stand once any beat leaving this edge is counted.
      cnt_after = beat_cnt_q;
      if (xfer) begin
         cnt_after = tlast_q ? 32'd0 : beat_cnt_q + 32'd1;
      end

      // >= (not ==) so that lowering the interval mid-group still closes it.
      last_for_load = (tlast_interval <= 32'd1) || (cnt_after >= tlast_interval - 32'd1);
   end

   always_comb begin
      tvalid_d   = tvalid_q;
      tdata_d    = tdata_q;
      tlast_d    = tlast_q;
      beat_cnt_d = cnt_after;
      if (load) begin
         tvalid_d = 1'b1;
         tdata_d  = packet;
         tlast_d  = last_for_load;
      end else if (xfer) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         tlast_q    <= 1'b0;
         beat_cnt_q <= 32'd0;
      end else begin
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         tlast_q    <= tlast_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign M_AXIS_tvalid = tvalid_q;
   assign M_AXIS_tdata  = tdata_q;
   assign M_AXIS_tlast  = tlast_q;

endmodule

// File: tb/tb_continuous_monitoring_system.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor checks them.
module tb_continuous_monitoring_system;

   localparam int XLEN = 64;
   localparam int W    = XLEN + 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [31:0]     instr;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic            tvalid;
   logic            tready;
   logic [W-1:0]    tdata;
   logic            tlast;
   logic [31:0]     tlast_interval;

   continuous_monitoring_system #(.XLEN(XLEN), .AXI_DATA_WIDTH(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr          (instr),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .M_AXIS_tvalid  (tvalid),
      .M_AXIS_tready  (tready),
      .M_AXIS_tdata   (tdata),
      .M_AXIS_tlast   (tlast),
      .tlast_interval (tlast_interval)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   beat_t exp_q[$];
   int    tests = 0;
   int    fails = 0;
   int    n_xfer = 0;
   int    n_last = 0;

   // Reference model: one pending beat slot plus beats-transferred-in-group count.
   bit      m_pending = 0;
   bit      m_last    = 0;
   longint  m_cnt     = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit model_event(input logic pv, input logic [31:0] ins);
      logic [6:0] op;
      op = ins[6:0];
`ifdef CMS_BRANCH_FILTER_EN
      return pv && (op == 7'h63 || op == 7'h6f || op == 7'h67);
`else
      return pv && (op == op);
`endif
   endfunction

   // Called at posedge+2: apply inputs, predict the coming edge, advance one cycle.
   task automatic step(input logic pv, input logic [31:0] ins, input logic [XLEN-1:0] p,
                       input logic rdy);
      bit    do_load;
      beat_t b;
      pc_valid = pv;
      instr    = ins;
      pc       = p;
      tready   = rdy;
      do_load  = 0;
      if (m_pending && rdy) begin
         m_cnt     = m_last ? 0 : m_cnt + 1;
         m_pending = 0;
      end
      if (model_event(pv, ins) && !m_pending) begin
         m_pending = 1;
         m_last    = (tlast_interval <= 1) || (m_cnt >= longint'(tlast_interval) - 1);
         b.data    = {32'h0, ins, p};
         b.last    = m_last;
         do_load   = 1;
      end
      @(posedge clk);
      if (do_load) exp_q.push_back(b);
      #2;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("tvalid", {127'h0, tvalid}, {127'h0, exp_q.size() != 0});
         if (tvalid && exp_q.size() != 0) begin
            chk("tdata", {32'h0, tdata}, {32'h0, exp_q[0].data});
            chk("tlast", {127'h0, tlast}, {127'h0, exp_q[0].last});
            if (tready) begin
               n_xfer++;
               if (tlast) n_last++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] ops[6];
      int          l0;
      rst_n = 1'b0; instr = 32'h0; pc = '0; pc_valid = 1'b0; tready = 1'b1;
      tlast_interval = 32'd3;
      ops[0] = 32'h0000_0063; ops[1] = 32'h0000_006f; ops[2] = 32'h0000_0067;
      ops[3] = 32'h0013_0013; ops[4] = 32'h0000_0033; ops[5] = 32'h0000_0000;

      #1;
      chk("reset_tvalid", {127'h0, tvalid}, 128'h0);
      chk("reset_tlast", {127'h0, tlast}, 128'h0);
      chk("reset_tdata", {32'h0, tdata}, 128'h0);
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Single JAL at pc 8, then idle.
      step(1, 32'h0000006f, 64'h8, 1);
      step(0, 32'h0, 64'h0, 1);
      // Non-control instructions and pc_valid=0 with JALR.
      step(1, 32'h00130013, 64'h10, 1);
      step(1, 32'h00000000, 64'h14, 1);
      step(0, 32'h00000067, 64'h18, 1);
      step(0, 32'h0, 64'h0, 1);

      // Reset to align group start, then six back-to-back control-flow events.
      rst_n = 1'b0; exp_q.delete(); m_pending = 0; m_last = 0; m_cnt = 0;
      @(posedge clk); #2; rst_n = 1'b1;
      l0 = n_last;
      for (int i = 0; i < 6; i++) step(1, ops[i % 3] | (i << 7), 64'h100 + 4 * i, 1);
      step(0, 32'h0, 64'h0, 1);
      step(0, 32'h0, 64'h0, 1);
      chk("group3_tlast_count", 128'(n_last - l0), 128'd2);

      // Stall three cycles while events arrive, then release.
      step(1, 32'h0000_0063, 64'h200, 0);
      for (int i = 0; i < 3; i++) step(1, 32'h0000_006f, 64'h300 + 4 * i, 0);
      step(0, 32'h0, 64'h0, 1);
      step(0, 32'h0, 64'h0, 1);

      // Reset mid-group with a stalled beat pending.
      step(1, 32'h0000_006f, 64'h400, 1);
      step(1, 32'h0000_0067, 64'h404, 0);
      rst_n = 1'b0;
      #1;
      chk("midreset_tvalid", {127'h0, tvalid}, 128'h0);
      chk("midreset_tlast", {127'h0, tlast}, 128'h0);
      chk("midreset_tdata", {32'h0, tdata}, 128'h0);
      exp_q.delete(); m_pending = 0; m_last = 0; m_cnt = 0;
      @(posedge clk); #2; rst_n = 1'b1;
      l0 = n_last;
      for (int i = 0; i < 3; i++) step(1, 32'h0000_0063, 64'h500 + 4 * i, 1);
      step(0, 32'h0, 64'h0, 1);
      chk("postreset_group_last", 128'(n_last - l0), 128'd1);

      // Randomized traffic with occasional interval changes.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         if ($urandom_range(0, 19) == 0) tlast_interval = $urandom_range(0, 5);
         ins = ops[$urandom_range(0, 5)] | ($urandom() & 32'hffff_ff80);
         step($urandom_range(0, 3) != 0, ins, {$urandom(), $urandom()},
              $urandom_range(0, 9) < 7);
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 32'h0, 64'h0, 1);
      chk("drain_empty", 128'(exp_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
